// File: rtl/crc_ram_sequencer.sv
// crc_ram_sequencer
//   Command-driven controller for one port of the dual-port CRC RAM. A command
//   streams a byte range out of the RAM (one read per cycle), runs
//   CRC-16/CCITT-FALSE over it, and then either reports the CRC (mode 0/3),
//   appends it big-endian after the range (mode 1), or checks for a zero
//   residue over a range that already carries its CRC (mode 2).
//
// Ports
//   clk_clk, reset_reset           clock, asynchronous active-high reset
//   cmd_valid/cmd_ready            command handshake (ready only in IDLE)
//   cmd_base[7:0]                  first RAM address
//   cmd_len[8:0]                   byte count, saturated to 256
//   cmd_mode[1:0]                  0 compute, 1 append, 2 verify, 3 as 0
//   mem_*                          RAM port (address, chipselect, clken,
//                                  write, writedata, readdata)
//   busy                           high outside IDLE
//   done_valid                     one-cycle completion pulse
//   done_crc[15:0], done_ok        held results of the last completion
module crc_ram_sequencer #(
  parameter int          RD_LATENCY = 1,
  parameter logic [15:0] POLY       = 16'h1021,
  parameter logic [15:0] INIT       = 16'hFFFF
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_base,
  input  logic [8:0]  cmd_len,
  input  logic [1:0]  cmd_mode,
  output logic [7:0]  mem_address,
  output logic        mem_chipselect,
  output logic        mem_clken,
  output logic        mem_write,
  output logic [7:0]  mem_writedata,
  input  logic [7:0]  mem_readdata,
  output logic        busy,
  output logic        done_valid,
  output logic [15:0] done_crc,
  output logic        done_ok
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_WR_HI,
    S_WR_LO,
    S_DONE
  } state_t;

  // Oldest slot of the return-tag pipe; that slot lines up with readdata.
  localparam logic [RD_LATENCY-1:0] TAG_TOP = RD_LATENCY'(1 << (RD_LATENCY - 1));

  state_t                  state_q, state_d;
  logic [8:0]              idx_q, idx_d;
  logic [RD_LATENCY-1:0]   tag_q, tag_d;
  logic [15:0]             done_crc_q, done_crc_d;
  logic                    done_ok_q, done_ok_d;

  logic [7:0]              base_q, base_d;
  logic [8:0]              len_q, len_d;
  logic [1:0]              mode_q, mode_d;
  logic [15:0]             crc_q, crc_d;

  logic [8:0]              len_sat;
  logic                    issue;

  // One byte of CRC-16, MSB first, eight shift/XOR steps unrolled.
  function automatic logic [15:0] crc_byte(input logic [15:0] c_in,
                                           input logic [7:0]  b);
    logic [15:0] c;
    c = c_in ^ {b, 8'h00};
    for (int k = 0; k < 8; k++) begin
      if (c[15]) c = {c[14:0], 1'b0} ^ POLY;
      else       c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  always_comb begin
    len_sat        = (cmd_len > 9'd256) ? 9'd256 : cmd_len;
    state_d        = state_q;
    idx_d          = idx_q;
    base_d         = base_q;
    len_d          = len_q;
    mode_d         = mode_q;
    done_crc_d     = done_crc_q;
    done_ok_d      = done_ok_q;
    issue          = 1'b0;
    mem_address    = 8'h00;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_writedata  = 8'h00;

    // Returning read beat folds into the CRC in the cycle it is tagged.
    crc_d = crc_q;
    if (tag_q[RD_LATENCY-1]) crc_d = crc_byte(crc_q, mem_readdata);

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          base_d = cmd_base;
          len_d  = len_sat;
          mode_d = cmd_mode;
          idx_d  = 9'd0;
          crc_d  = INIT;
          if (len_sat == 9'd0) state_d = (cmd_mode == 2'd1) ? S_WR_HI : S_DONE;
          else                 state_d = S_READ;
        end
      end
      S_READ: begin
        issue          = 1'b1;
        mem_chipselect = 1'b1;
        mem_address    = base_q + idx_q[7:0];
        idx_d          = idx_q + 9'd1;
        if (idx_q == len_q - 9'd1) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Leave once the only outstanding beat is the one landing this cycle.
        if ((tag_q & ~TAG_TOP) == '0) state_d = (mode_q == 2'd1) ? S_WR_HI : S_DONE;
      end
      S_WR_HI: begin
        mem_chipselect = 1'b1;
        mem_write      = 1'b1;
        mem_address    = base_q + len_q[7:0];
        mem_writedata  = crc_q[15:8];
        state_d        = S_WR_LO;
      end
      S_WR_LO: begin
        mem_chipselect = 1'b1;
        mem_write      = 1'b1;
        mem_address    = base_q + len_q[7:0] + 8'd1;
        mem_writedata  = crc_q[7:0];
        state_d        = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    tag_d = (tag_q << 1) | RD_LATENCY'(issue);

    // Results are captured on entry to DONE so they are visible with the pulse.
    if (state_d == S_DONE && state_q != S_DONE) begin
      done_crc_d = crc_d;
      done_ok_d  = (mode_d == 2'd2) && (crc_d == 16'h0000) && (len_d >= 9'd2);
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q    <= S_IDLE;
      idx_q      <= 9'd0;
      tag_q      <= '0;
      done_crc_q <= 16'h0000;
      done_ok_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tag_q      <= tag_d;
      done_crc_q <= done_crc_d;
      done_ok_q  <= done_ok_d;
    end
  end

  // Command operands and CRC accumulator are only consumed after an accept.
  always_ff @(posedge clk_clk) begin
    base_q <= base_d;
    len_q  <= len_d;
    mode_q <= mode_d;
    crc_q  <= crc_d;
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign done_valid = (state_q == S_DONE);
  assign done_crc   = done_crc_q;
  assign done_ok    = done_ok_q;
  assign mem_clken  = ~reset_reset;

endmodule
